// File: rtl/ieee_754_subtractor.sv
// Registered binary32 subtractor: result = a - b, rounded toward negative infinity.
// Subnormal operands are flushed to zero; exact cancellation returns +0.
`timescale 1ns/1ps
module ieee_754_subtractor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        out_valid
);

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;
  localparam logic [31:0] POS_MAX = 32'h7F7F_FFFF;

  typedef struct packed {
    logic signed [9:0] exp;
    logic [22:0]       frac;
  } rnd_t;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 5'd1;
      end
    end
    return n;
  endfunction

  // Negative magnitudes move away from zero when any discarded bit is set.
  function automatic rnd_t round_rtn(input logic sign, input logic [23:0] mant,
                                     input logic [2:0] grs, input logic signed [9:0] exp);
    rnd_t       r;
    logic [24:0] sum;
    sum = {1'b0, mant} + {24'd0, (sign && (grs != 3'b000))};
    if (sum[24]) begin
      r.frac = sum[23:1];
      r.exp  = exp + 10'sd1;
    end else begin
      r.frac = sum[22:0];
      r.exp  = exp;
    end
    return r;
  endfunction

  function automatic logic [31:0] saturate(input logic sign, input rnd_t r);
    logic [31:0] w;
    if (r.exp >= 10'sd255)    w = sign ? NEG_INF : POS_MAX;
    else if (r.exp <= 10'sd0) w = {sign, 31'd0};
    else                      w = {sign, r.exp[7:0], r.frac};
    return w;
  endfunction

  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        a_big;
  logic        sl, ss;
  logic [7:0]  el, es, dexp;
  logic [23:0] ml, ms;
  logic [49:0] wide;
  logic [26:0] ml_x, ms_x;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [26:0] norm;
  logic signed [9:0] exp_n;
  rnd_t        rnd;
  logic [31:0] diff;
  logic [31:0] result_d, result_q;
  logic        out_valid_d, out_valid_q;

  always_comb begin
    sa     = a[31];
    sb     = ~b[31];
    ea     = a[30:23];
    eb     = b[30:23];
    fa     = a[22:0];
    fb     = b[22:0];
    a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);

    a_big = {ea, fa} >= {eb, fb};
    sl    = a_big ? sa : sb;
    ss    = a_big ? sb : sa;
    el    = a_big ? ea : eb;
    es    = a_big ? eb : ea;
    ml    = a_big ? {1'b1, fa} : {1'b1, fb};
    ms    = a_big ? {1'b1, fb} : {1'b1, fa};
    dexp  = el - es;

    // Smaller operand aligned into 24 bits + guard + round, the rest folded into sticky.
    wide = {ms, 26'd0} >> dexp;
    if (dexp >= 8'd26) ms_x = 27'd1;
    else               ms_x = {wide[49:24], |wide[23:0]};
    ml_x = {ml, 3'b000};

    if (sl == ss) sum = {1'b0, ml_x} + {1'b0, ms_x};
    else          sum = {1'b0, ml_x} - {1'b0, ms_x};

    lz = lzc27(sum[26:0]);
    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_n = $signed({2'b00, el}) + 10'sd1;
    end else begin
      norm  = sum[26:0] << lz;
      exp_n = $signed({2'b00, el}) - $signed({5'd0, lz});
    end

    rnd = round_rtn(sl, norm[26:3], norm[2:0], exp_n);

    if (a_nan || b_nan)                   diff = QNAN;
    else if (a_inf && b_inf && (sa != sb)) diff = QNAN;
    else if (a_inf)                       diff = a;
    else if (b_inf)                       diff = {sb, b[30:0]};
    else if (a_zero && b_zero)            diff = (sa == sb) ? {sa, 31'd0} : 32'd0;
    else if (a_zero)                      diff = {sb, b[30:0]};
    else if (b_zero)                      diff = a;
    else if ((a[30:0] == b[30:0]) && (sa != sb)) diff = 32'd0;
    else                                  diff = saturate(sl, rnd);

    result_d    = in_valid ? diff : result_q;
    out_valid_d = in_valid;
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ieee_754_subtractor.sv
// Bench for ieee_754_subtractor: directed vectors, reset/hold behaviour, and
// randomized operands against an exact integer reference model.
`timescale 1ns/1ps
module tb_ieee_754_subtractor;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;
  localparam logic [31:0] POS_MAX = 32'h7F7F_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a_i, b_i;
  logic [31:0] result;
  logic        out_valid;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  ieee_754_subtractor dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a_i),
    .b        (b_i),
    .result   (result),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Exact reference: operands as scaled integers, exact signed sum, then RTN rounding.
  function automatic logic [31:0] ref_sub(input logic [31:0] x, input logic [31:0] y);
    logic        sx, sy, neg;
    int          ex, ey, d, sh, base, p, e;
    longint      mx, my, vx, vy, dsum;
    logic [63:0] mag, q, rmask;
    sx = x[31];
    sy = ~y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0)) return QNAN;
    if (ex == 255 && ey == 255) return (sx != sy) ? QNAN : x;
    if (ex == 255) return x;
    if (ey == 255) return {sy, y[30:0]};
    if (ex == 0 && ey == 0) return (sx == sy) ? {sx, 31'd0} : 32'd0;
    if (ex == 0) return {sy, y[30:0]};
    if (ey == 0) return x;
    mx = longint'({40'd0, 1'b1, x[22:0]});
    my = longint'({40'd0, 1'b1, y[22:0]});
    d  = ex - ey;
    if (d >= 0) begin
      sh   = (d > 36) ? 36 : d;
      base = ex - sh;
      mx   = mx << sh;
      if (d > 36) my = 1;
    end else begin
      sh   = (-d > 36) ? 36 : -d;
      base = ey - sh;
      my   = my << sh;
      if (-d > 36) mx = 1;
    end
    vx   = sx ? -mx : mx;
    vy   = sy ? -my : my;
    dsum = vx + vy;
    if (dsum == 0) return 32'd0;
    neg = (dsum < 0);
    mag = neg ? 64'(-dsum) : 64'(dsum);
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    e = base + p - 23;
    if (p > 23) begin
      q     = mag >> (p - 23);
      rmask = (64'd1 << (p - 23)) - 64'd1;
      if (neg && ((mag & rmask) != 64'd0)) q = q + 64'd1;
      if (q[24]) begin
        q = q >> 1;
        e = e + 1;
      end
    end else begin
      q = mag << (23 - p);
    end
    if (e >= 255) return neg ? NEG_INF : POS_MAX;
    if (e <= 0) return {neg, 31'd0};
    return {neg, e[7:0], q[22:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    in_valid = v;
    a_i      = x;
    b_i      = y;
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string tag, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp);
    step(1'b1, x, y);
    check(tag, result, exp);
    check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb, hold;
    int          ex, mode;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a_i      = 32'd0;
    b_i      = 32'd0;
    #1;
    check("reset_result", result, 32'd0);
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    vec("3m2", 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000);
    vec("4m2", 32'h4080_0000, 32'h4000_0000, 32'h4000_0000);
    vec("n2m3", 32'hC000_0000, 32'h4040_0000, 32'hC0A0_0000);
    vec("n3mn2", 32'hC040_0000, 32'hC000_0000, 32'hBF80_0000);
    vec("n1m0p3125", 32'hBF80_0000, 32'h3EA0_0000, 32'hBFA8_0000);
    vec("cancel", 32'h4000_0000, 32'h4000_0000, 32'h0000_0000);
    vec("p0mn0", 32'h0000_0000, 32'h8000_0000, 32'h0000_0000);
    vec("n0mp0", 32'h8000_0000, 32'h0000_0000, 32'h8000_0000);
    vec("inf_a", 32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000);
    vec("inf_inf", 32'h7F80_0000, 32'h7F80_0000, QNAN);
    vec("nan_a", 32'h7FC0_0000, 32'h4000_0000, QNAN);
    vec("inf_b", 32'h4000_0000, 32'h7F80_0000, NEG_INF);
    vec("ovf_neg", 32'hFF7F_FFFF, 32'h7F7F_FFFF, NEG_INF);
    vec("ovf_pos", 32'h7F7F_FFFF, 32'hFF7F_FFFF, POS_MAX);
    vec("rnd_trunc", 32'h3F80_0000, 32'h3280_0000, 32'h3F7F_FFFF);
    vec("rnd_down", 32'h3280_0000, 32'h3F80_0000, 32'hBF80_0000);
    vec("subn_a", 32'h0000_0001, 32'h4000_0000, 32'hC000_0000);
    vec("subn_b", 32'h4000_0000, 32'h8040_0000, 32'h4000_0000);

    // Hold: result keeps its value, valid drops.
    hold = result;
    step(1'b0, 32'h4040_0000, 32'h3F80_0000);
    check("hold_result", result, hold);
    check("hold_valid", {31'd0, out_valid}, 32'd0);

    // Reset mid-stream with an operation in flight.
    vec("pre_rst", 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000);
    @(negedge clk);
    in_valid = 1'b1;
    a_i      = 32'h4080_0000;
    b_i      = 32'h4000_0000;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_result", result, 32'd0);
    check("rst_async_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_result", result, 32'd0);
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    vec("first_after_rst", 32'h4080_0000, 32'h4000_0000, 32'h4000_0000);

    // Randomized operands, back-to-back.
    for (int i = 0; i < 400; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      mode = $urandom_range(0, 3);
      ex   = int'(ra[30:23]);
      if (mode == 1) begin
        ex = ex + $urandom_range(0, 6) - 3;
        if (ex < 1) ex = 1;
        if (ex > 254) ex = 254;
        rb[30:23] = ex[7:0];
      end else if (mode == 2) begin
        rb = {rb[31], ra[30:4], rb[3:0]};
      end else if (mode == 3) begin
        ex = $urandom_range(250, 254);
        ra[30:23] = ex[7:0];
        ex = $urandom_range(248, 254);
        rb[30:23] = ex[7:0];
      end
      step(1'b1, ra, rb);
      check($sformatf("rnd%0d_%h_%h", i, ra, rb), result, ref_sub(ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
